// File: rtl/flt2fix_seq.sv
// Multi-cycle float-to-fixed converter: unpacks {sign, exp, frac}, shifts one bit per cycle,
// optionally rounds to nearest even, then packs a saturating signed INT_W.FRAC_W result.
module flt2fix_seq #(
   parameter int EXP_W  = 5,
   parameter int MAN_W  = 10,
   parameter int INT_W  = 8,
   parameter int FRAC_W = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [EXP_W+MAN_W:0]    i_flt_in,
   input  logic                    i_round_mode,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [INT_W+FRAC_W-1:0] o_fix_out,
   output logic                    o_ovf,
   output logic                    o_inexact
);

   localparam int W     = INT_W + FRAC_W;
   localparam int MAG_W = W + 1;
   localparam int SW    = EXP_W + 8;

   localparam logic signed [SW-1:0] BIAS_S = SW'(2**(EXP_W-1) - 1);
   localparam logic signed [SW-1:0] OFFS_S = SW'(FRAC_W - MAN_W);
   localparam logic signed [SW-1:0] INTW_S = SW'(INT_W);
   localparam logic [SW-1:0]        CLAMP  = SW'(MAN_W + 2);
   localparam logic [SW-1:0]        ONE_C  = SW'(1);
   localparam logic [W-1:0]         MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]         MIN_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [MAG_W-1:0]     POS_LIM = {2'b00, {(W-1){1'b1}}};
   localparam logic [MAG_W-1:0]     NEG_LIM = {2'b01, {(W-1){1'b0}}};
   localparam logic [MAG_W-1:0]     MAG_ONE = {{(MAG_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SHIFT, S_ROUND, S_PACK} state_t;

   state_t             r_state, w_state_nxt;
   logic               r_sign, r_rne, r_left, r_guard, r_sticky, r_inx;
   logic [EXP_W-1:0]   r_exp;
   logic [MAN_W-1:0]   r_frac;
   logic [MAG_W-1:0]   r_mag;
   logic [SW-1:0]      r_cnt;
   logic               r_busy, r_done, r_ovf, r_inexact;
   logic [W-1:0]       r_fix;

   logic [EXP_W-1:0]   w_exp_eff;
   logic signed [SW-1:0] w_e, w_sh;
   logic [SW-1:0]      w_abs, w_n;
   logic [MAN_W:0]     w_m;
   logic               w_exp_ones, w_too_big, w_zero, w_exit, w_round_up;
   logic [W-1:0]       w_neg;

   // Subnormals use an effective exponent of 1 with no hidden bit.
   assign w_exp_eff  = (r_exp == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : r_exp;
   assign w_e        = $signed({{(SW-EXP_W){1'b0}}, w_exp_eff}) - BIAS_S;
   assign w_sh       = w_e + OFFS_S;
   assign w_abs      = w_sh[SW-1] ? $unsigned(-w_sh) : $unsigned(w_sh);
   assign w_n        = (w_sh[SW-1] && (w_abs > CLAMP)) ? CLAMP : w_abs;
   assign w_m        = {|r_exp, r_frac};
   assign w_exp_ones = &r_exp;
   assign w_too_big  = (w_e >= INTW_S);
   assign w_zero     = (w_m == {(MAN_W+1){1'b0}});
   assign w_exit     = w_exp_ones | w_too_big | w_zero;
   assign w_round_up = r_rne & r_guard & (r_sticky | r_mag[0]);
   assign w_neg      = -r_mag[W-1:0];

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_UNPACK;
            else         w_state_nxt = S_IDLE;
         end
         S_UNPACK: begin
            if (w_exit)                     w_state_nxt = S_IDLE;
            else if (w_sh == {SW{1'b0}})    w_state_nxt = S_ROUND;
            else                            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == ONE_C) w_state_nxt = S_ROUND;
            else                w_state_nxt = S_SHIFT;
         end
         S_ROUND: w_state_nxt = S_PACK;
         S_PACK:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, shift/round datapath and registered results.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sign <= 1'b0;  r_rne <= 1'b0;  r_left <= 1'b0;
         r_guard <= 1'b0; r_sticky <= 1'b0; r_inx <= 1'b0;
         r_exp <= {EXP_W{1'b0}}; r_frac <= {MAN_W{1'b0}};
         r_mag <= {MAG_W{1'b0}}; r_cnt <= {SW{1'b0}};
         r_busy <= 1'b0; r_done <= 1'b0; r_ovf <= 1'b0; r_inexact <= 1'b0;
         r_fix <= {W{1'b0}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_sign <= i_flt_in[EXP_W+MAN_W];
                  r_exp  <= i_flt_in[EXP_W+MAN_W-1:MAN_W];
                  r_frac <= i_flt_in[MAN_W-1:0];
                  r_rne  <= i_round_mode;
                  r_busy <= 1'b1;
               end
            end
            S_UNPACK: begin
               r_mag    <= {{(MAG_W-MAN_W-1){1'b0}}, w_m};
               r_guard  <= 1'b0;
               r_sticky <= 1'b0;
               r_cnt    <= w_n;
               r_left   <= ~w_sh[SW-1];
               // Inf/NaN and out-of-range exponents finish here without shifting.
               if (w_exp_ones) begin
                  r_busy <= 1'b0; r_done <= 1'b1; r_ovf <= 1'b1; r_inexact <= 1'b0;
                  r_fix  <= (r_frac != {MAN_W{1'b0}}) ? {W{1'b0}} : (r_sign ? MIN_NEG : MAX_POS);
               end else if (w_too_big) begin
                  r_busy <= 1'b0; r_done <= 1'b1; r_ovf <= 1'b1; r_inexact <= 1'b0;
                  r_fix  <= r_sign ? MIN_NEG : MAX_POS;
               end else if (w_zero) begin
                  r_busy <= 1'b0; r_done <= 1'b1; r_ovf <= 1'b0; r_inexact <= 1'b0;
                  r_fix  <= {W{1'b0}};
               end
            end
            S_SHIFT: begin
               r_cnt <= r_cnt - ONE_C;
               if (r_left) begin
                  r_mag <= {r_mag[MAG_W-2:0], 1'b0};
               end else begin
                  r_mag    <= {1'b0, r_mag[MAG_W-1:1]};
                  r_guard  <= r_mag[0];
                  r_sticky <= r_sticky | r_guard;
               end
            end
            S_ROUND: begin
               r_inx <= r_guard | r_sticky;
               if (w_round_up) r_mag <= r_mag + MAG_ONE;
            end
            S_PACK: begin
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_inexact <= r_inx;
               if (!r_sign && (r_mag > POS_LIM)) begin
                  r_fix <= MAX_POS; r_ovf <= 1'b1;
               end else if (r_sign && (r_mag > NEG_LIM)) begin
                  r_fix <= MIN_NEG; r_ovf <= 1'b1;
               end else begin
                  r_fix <= r_sign ? w_neg : r_mag[W-1:0];
                  r_ovf <= 1'b0;
               end
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_fix_out = r_fix;
   assign o_ovf     = r_ovf;
   assign o_inexact = r_inexact;

endmodule
